// File: rtl/agc_pkg.sv
// Shared constants and the FSM state type for the AGC RMS/scale stage.
package agc_pkg;

  localparam int AGC_SQ_BITS    = 24;
  localparam int AGC_RMS_BITS   = 12;
  localparam int AGC_NUM_SHIFT  = 22;
  localparam int AGC_SCALE_BITS = 17;

  // Q5.12 unity gain
  localparam logic [AGC_SCALE_BITS-1:0] AGC_UNITY_SCALE = 17'd4096;
  // Bias the square accumulator carries into this stage
  localparam logic [AGC_SQ_BITS-1:0]    AGC_SQ_OFFSET   = 24'd16384;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SQRT  = 2'd1,
    RECIP = 2'd2,
    DONE  = 2'd3
  } agc_rms_state_t;

endpackage

// File: rtl/agc_iter_sqrt.sv
// Iterative non-restoring integer square root, one root bit per cycle,
// MSB first. start_i loads the radicand; done_o is high during the cycle
// whose clock edge computes the last bit, and root_o then carries the
// final floor(sqrt(radicand)).
module agc_iter_sqrt #(
  parameter int RAD_BITS = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [RAD_BITS-1:0]   rad_i,
  output logic                  done_o,
  output logic [RAD_BITS/2-1:0] root_o
);

  localparam int ROOT_BITS = RAD_BITS / 2;
  // Signed partial remainder; a few guard bits above the root width
  localparam int REM_BITS  = ROOT_BITS + 5;
  localparam int PAD_BITS  = REM_BITS - ROOT_BITS - 2;
  localparam int CNT_W     = $clog2(ROOT_BITS);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(ROOT_BITS - 1);

  logic                 r_active;
  logic [CNT_W-1:0]     r_cnt;
  logic [RAD_BITS-1:0]  r_rad;
  logic [REM_BITS-1:0]  r_rem;
  logic [ROOT_BITS-1:0] r_root;

  logic [REM_BITS-1:0]  w_rem_sh;
  logic [REM_BITS-1:0]  w_rem_nxt;
  logic [ROOT_BITS-1:0] w_root_nxt;

  // One non-restoring step: bring down two radicand bits, then subtract
  // (4Q+1) after a non-negative remainder or add (4Q+3) after a negative one.
  always_comb begin
    w_rem_sh = {r_rem[REM_BITS-3:0], r_rad[RAD_BITS-1 -: 2]};
    if (r_rem[REM_BITS-1] == 1'b0) begin
      w_rem_nxt = w_rem_sh - {{PAD_BITS{1'b0}}, r_root, 2'b01};
    end else begin
      w_rem_nxt = w_rem_sh + {{PAD_BITS{1'b0}}, r_root, 2'b11};
    end
    w_root_nxt = {r_root[ROOT_BITS-2:0], ~w_rem_nxt[REM_BITS-1]};
  end

  assign done_o = r_active && (r_cnt == L_LAST);
  assign root_o = w_root_nxt;

  // Iteration state: load on start, then shift one root bit per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_rad    <= '0;
      r_rem    <= '0;
      r_root   <= '0;
    end else if (start_i) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_rad    <= rad_i;
      r_rem    <= '0;
      r_root   <= '0;
    end else if (r_active) begin
      r_rem    <= w_rem_nxt;
      r_root   <= w_root_nxt;
      r_rad    <= {r_rad[RAD_BITS-3:0], 2'b00};
      r_cnt    <= r_cnt + CNT_W'(1);
      r_active <= (r_cnt != L_LAST);
    end else begin
      r_active <= r_active;
    end
  end

endmodule

// File: rtl/agc_rms_scale.sv
// AGC RMS / gain-scale stage: captures the square accumulator, takes an
// iterative square root, then a restoring reciprocal 2^NUM_SHIFT / rms.
// Optional build macro: AGC_RMS_SCALE_ROUND_EN (round-to-nearest reciprocal).
module agc_rms_scale
  import agc_pkg::*;
#(
  parameter int SQ_BITS    = AGC_SQ_BITS,
  parameter int NUM_SHIFT  = AGC_NUM_SHIFT,
  parameter int SCALE_BITS = AGC_SCALE_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  calc_i,
  input  logic [SQ_BITS-1:0]    sq_accum_i,
  output logic                  busy_o,
  output logic [SQ_BITS/2-1:0]  rms_o,
  output logic [SCALE_BITS-1:0] scale_o,
  output logic                  valid_o
);

  localparam int RMS_BITS = SQ_BITS / 2;
  localparam int DVD_W    = NUM_SHIFT + 1;
  localparam int QUO_W    = NUM_SHIFT + 1;
`ifdef AGC_RMS_SCALE_ROUND_EN
  localparam int REM_W    = NUM_SHIFT + 3;
`else
  localparam int REM_W    = NUM_SHIFT + 2;
`endif
  localparam int CNT_W    = $clog2(QUO_W);
  localparam logic [CNT_W-1:0]      L_DIV_LAST  = CNT_W'(QUO_W - 1);
  localparam logic [DVD_W-1:0]      L_NUM       = {1'b1, {NUM_SHIFT{1'b0}}};
  localparam logic [SCALE_BITS-1:0] L_SCALE_MAX = {SCALE_BITS{1'b1}};
  localparam logic [SCALE_BITS-1:0] L_UNITY     = SCALE_BITS'(AGC_UNITY_SCALE);

  agc_rms_state_t r_state;
  agc_rms_state_t w_state_nxt;
  logic           w_sqrt_start;
  logic           w_sqrt_done;
  logic [RMS_BITS-1:0] w_root;

  logic                  r_busy;
  logic                  r_valid;
  logic [RMS_BITS-1:0]   r_rms_out;
  logic [SCALE_BITS-1:0] r_scale;
  logic [RMS_BITS-1:0]   r_rms;
  logic [DVD_W-1:0]      r_dvd;
  logic [REM_W-1:0]      r_rem;
  logic [QUO_W-1:0]      r_quo;
  logic [CNT_W-1:0]      r_cnt;

  logic [DVD_W-1:0]      w_dividend;
  logic [REM_W-1:0]      w_rem_sh;
  logic [REM_W-1:0]      w_rem_nxt;
  logic                  w_qbit;
  logic [SCALE_BITS-1:0] w_scale;

  agc_iter_sqrt #(
    .RAD_BITS (SQ_BITS)
  ) u_sqrt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (w_sqrt_start),
    .rad_i   (sq_accum_i),
    .done_o  (w_sqrt_done),
    .root_o  (w_root)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; calc_i is only honoured in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_sqrt_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (calc_i) begin
          w_sqrt_start = 1'b1;
          w_state_nxt  = SQRT;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      SQRT: begin
        if (w_sqrt_done) begin
          w_state_nxt = RECIP;
        end else begin
          w_state_nxt = SQRT;
        end
      end
      RECIP: begin
        if (r_cnt == L_DIV_LAST) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RECIP;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Restoring division step and final saturation of the quotient.
  always_comb begin
`ifdef AGC_RMS_SCALE_ROUND_EN
    w_dividend = L_NUM + DVD_W'(w_root >> 1);
`else
    w_dividend = L_NUM;
`endif
    w_rem_sh = {r_rem[REM_W-2:0], r_dvd[DVD_W-1]};
    w_qbit   = (w_rem_sh >= REM_W'(r_rms));
    if (w_qbit) begin
      w_rem_nxt = w_rem_sh - REM_W'(r_rms);
    end else begin
      w_rem_nxt = w_rem_sh;
    end
    if ((r_rms == '0) || (r_quo > QUO_W'(L_SCALE_MAX))) begin
      w_scale = L_SCALE_MAX;
    end else begin
      w_scale = r_quo[SCALE_BITS-1:0];
    end
  end

  // Datapath and registered outputs; outputs only move in DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_rms_out <= '0;
      r_scale   <= L_UNITY;
      r_rms     <= '0;
      r_dvd     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (calc_i) begin
            r_busy <= 1'b1;
            r_rms  <= '0;
            r_dvd  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
          end else begin
            r_busy <= 1'b0;
          end
        end
        SQRT: begin
          if (w_sqrt_done) begin
            r_rms <= w_root;
            r_dvd <= w_dividend;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
          end else begin
            r_cnt <= '0;
          end
        end
        RECIP: begin
          // A zero rms leaves the quotient untouched; DONE saturates it.
          if (r_rms != '0) begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[QUO_W-2:0], w_qbit};
          end else begin
            r_quo <= r_quo;
          end
          r_dvd <= {r_dvd[DVD_W-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_rms_out <= r_rms;
          r_scale   <= w_scale;
          r_valid   <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = r_busy;
  assign valid_o = r_valid;
  assign rms_o   = r_rms_out;
  assign scale_o = r_scale;

endmodule

// File: tb/tb_agc_rms_scale.sv
// Scoreboard bench for agc_rms_scale: a driver pushes the expected result
// of each accepted calculation, a monitor pops and compares on valid_o.
module tb_agc_rms_scale;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        calc_i;
  logic [23:0] sq_accum_i;
  logic        busy_o;
  logic [11:0] rms_o;
  logic [16:0] scale_o;
  logic        valid_o;

  agc_rms_scale dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .calc_i     (calc_i),
    .sq_accum_i (sq_accum_i),
    .busy_o     (busy_o),
    .rms_o      (rms_o),
    .scale_o    (scale_o),
    .valid_o    (valid_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc = cyc + 1;

  typedef struct {
    longint rms;
    longint scale;
    int     c0;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: exact floor square root and 2^22/rms with saturation.
  function automatic longint ref_sqrt(input longint x);
    longint r;
    r = longint'($floor($sqrt(real'(x))));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic longint ref_scale(input longint rms);
    longint num, q;
    if (rms == 0) return 131071;
    num = 64'd4194304;
`ifdef AGC_RMS_SCALE_ROUND_EN
    num = num + rms / 2;
`endif
    q = num / rms;
    return (q > 131071) ? 131071 : q;
  endfunction

  // Monitor: every valid_o pulse must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got valid_o=1 with rms=%0d scale=%0d, expected no pulse", rms_o, scale_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rms", rms_o, e.rms);
        check("scale", scale_o, e.scale);
        check("latency", cyc - e.c0, 36);
      end
    end
  end

  // Pulse calc_i for one cycle; optionally register the expected result.
  task automatic issue(input logic [23:0] v, input bit expect_result, output int busy_seen);
    exp_t e;
    @(negedge clk_i);
    calc_i     = 1'b1;
    sq_accum_i = v;
    @(posedge clk_i);
    #1;
    if (expect_result) begin
      e.rms   = ref_sqrt(longint'(v));
      e.scale = ref_scale(e.rms);
      e.c0    = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk_i);
    calc_i     = 1'b0;
    sq_accum_i = 24'($urandom);
    busy_seen  = (busy_o === 1'b1) ? 1 : 0;
  endtask

  // Wait (bounded) for valid_o, counting busy cycles on the way.
  task automatic wait_done(input string name, input int busy_init, input bit chk_busy);
    int  busy_cnt;
    bit  seen;
    busy_cnt = busy_init;
    seen     = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy_o === 1'b1) busy_cnt++;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no valid_o within 80 cycles, expected a pulse", name);
    end else if (chk_busy) begin
      check({name, "_busy_cycles"}, busy_cnt, 36);
    end
  endtask

  initial begin
    int b;
    logic [23:0] v;
    logic [23:0] dir_vals [7];
    dir_vals = '{24'd1327104, 24'd16384, 24'd15745024, 24'd0, 24'd1024, 24'd1089, 24'd16777215};

    rst_i      = 1'b1;
    calc_i     = 1'b0;
    sq_accum_i = 24'd0;
    repeat (3) @(negedge clk_i);
    check("reset_busy", busy_o, 0);
    check("reset_valid", valid_o, 0);
    check("reset_rms", rms_o, 0);
    check("reset_scale", scale_o, 4096);
    rst_i = 1'b0;

    // Directed values including saturation boundaries.
    foreach (dir_vals[k]) begin
      issue(dir_vals[k], 1'b1, b);
      wait_done("directed", b, 1'b1);
    end
    check("hold_rms", rms_o, ref_sqrt(64'd16777215));

    // Second calc_i at cycle 10 of a calculation is ignored.
    issue(24'd1327104, 1'b1, b);
    repeat (9) @(negedge clk_i);
    calc_i     = 1'b1;
    sq_accum_i = 24'd16384;
    @(negedge clk_i);
    calc_i     = 1'b0;
    wait_done("ignored_calc", 0, 1'b0);
    repeat (40) @(negedge clk_i);

    // Reset at cycle 20 aborts without a valid pulse.
    issue(24'd15745024, 1'b0, b);
    repeat (19) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_valid", valid_o, 0);
    check("abort_rms", rms_o, 0);
    check("abort_scale", scale_o, 4096);
    repeat (40) @(negedge clk_i);
    issue(24'd1327104, 1'b1, b);
    wait_done("after_abort", b, 1'b1);

    // Simultaneous reset and calc: reset wins.
    @(negedge clk_i);
    rst_i  = 1'b1;
    calc_i = 1'b1;
    @(negedge clk_i);
    rst_i  = 1'b0;
    calc_i = 1'b0;
    check("rst_calc_busy", busy_o, 0);
    repeat (40) @(negedge clk_i);

    // Random sweep mixing full-range and small (saturating) values.
    for (int n = 0; n < 1500; n++) begin
      if (n % 4 == 0) v = 24'($urandom_range(0, 4000));
      else            v = 24'($urandom);
      issue(v, 1'b1, b);
      wait_done("random", b, 1'b0);
    end

    repeat (5) @(negedge clk_i);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
